adc_dma_reader: RTL

Reader end of the acquisition data FIFO: pulls 512-bit acquisition words from the FIFO filled by the acquisition path and emits them as 256-bit stream beats to the PCIe DMA card-to-host engine. The block runs on `clk_pcie_user`. It frames packets with `tlast` and reports transfer completion to the command logic. Each transfer is a fixed word count launched by `dma_start`.

---
 rtl/adc_dma_pkg.sv | 13 +
 rtl/adc_dma_wbuf.sv | 42 ++++
 rtl/adc_dma_reader.sv | 112 +++++++++++
 3 files changed

// File: rtl/adc_dma_pkg.sv
// Shared types and default widths for the acquisition FIFO -> DMA stream reader.
package adc_dma_pkg;
  localparam int DATA_W_DEF = 512;
  localparam int BEAT_W_DEF = 256;
  localparam int LEN_W_DEF  = 20;
  localparam int PKT_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/adc_dma_wbuf.sv
// Two-entry FIFO word buffer between the acquisition FIFO read port and the beat mux.
module adc_dma_wbuf
  import adc_dma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [1:0]        occ_o,
  output logic [DATA_W-1:0] head_o
);
  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage carries no reset; the consumer gates data on occupancy.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];
endmodule

// File: rtl/adc_dma_reader.sv
// Reads fixed-length transfers of DATA_W words from the acquisition FIFO and emits
// them as two BEAT_W stream beats each (low half first), framed into packets by tlast.
module adc_dma_reader
  import adc_dma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk_pcie_user,
  input  logic              reset,
  input  logic              dma_start,
  input  logic [LEN_W-1:0]  xfer_len_i,
  input  logic [PKT_W-1:0]  pkt_words_i,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [LEN_W-1:0]  word_cnt_o
);
  state_e            state_q;
  logic [LEN_W-1:0]  len_q, req_cnt_q, word_cnt_q;
  logic [PKT_W-1:0]  pkt_words_q, pkt_idx_q;
  logic              inflight_q, half_q, busy_q, done_q;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head;
  logic              tvalid, hs, pop, last_word, pkt_end;

  adc_dma_wbuf #(.DATA_W(DATA_W)) u_wbuf (
    .clk_i  (clk_pcie_user),
    .rst_i  (reset),
    .push_i (inflight_q),
    .pop_i  (pop),
    .data_i (fifo_dout),
    .occ_o  (occ),
    .head_o (head)
  );

  assign tvalid    = (state_q == S_RUN) && (occ != 2'd0);
  assign hs        = tvalid && m_axis_tready;
  assign pop       = hs && half_q;
  assign last_word = (word_cnt_q == len_q - 1'b1);
  assign pkt_end   = (pkt_idx_q == pkt_words_q - 1'b1);

  // Outstanding read counts against buffer space so a captured word always has a slot.
  assign fifo_rd_en = (state_q == S_RUN) && !fifo_empty && (req_cnt_q < len_q) &&
                      ((occ + {1'b0, inflight_q}) < 2'd2);

  assign m_axis_tvalid = tvalid;
  assign m_axis_tdata  = !tvalid ? '0 :
                         half_q  ? head[DATA_W-1:BEAT_W] : head[BEAT_W-1:0];
  assign m_axis_tlast  = tvalid && half_q && (pkt_end || last_word);
  assign dma_busy      = busy_q;
  assign dma_done      = done_q;
  assign word_cnt_o    = word_cnt_q;

  always_ff @(posedge clk_pcie_user) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      req_cnt_q   <= '0;
      word_cnt_q  <= '0;
      pkt_words_q <= '0;
      pkt_idx_q   <= '0;
      inflight_q  <= 1'b0;
      half_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= fifo_rd_en;
      case (state_q)
        S_IDLE: begin
          if (dma_start) begin
            len_q       <= xfer_len_i;
            pkt_words_q <= (pkt_words_i == '0) ? PKT_W'(1) : pkt_words_i;
            req_cnt_q   <= '0;
            word_cnt_q  <= '0;
            pkt_idx_q   <= '0;
            half_q      <= 1'b0;
            if (xfer_len_i != '0) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (fifo_rd_en) req_cnt_q <= req_cnt_q + 1'b1;
          if (hs) half_q <= ~half_q;
          if (pop) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            pkt_idx_q  <= (pkt_end || last_word) ? '0 : pkt_idx_q + 1'b1;
            if (last_word) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
